// File: rtl/ram_responder_pkg.sv
// Shared definitions for the SRAM responder: bus width macros, FSM state and operation encodings.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
`ifndef RAM_RESPONDER_DEFINES_SVH
`define RAM_RESPONDER_DEFINES_SVH
`define MemAddr  17:0
`define MemValue 15:0
`endif

package ram_responder_pkg;

    // STROBE2 exists only in the extra-wait build
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
`ifdef RAM_EXTRA_WAIT_EN
        ST_STROBE2 = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    // Read wins when both qualifiers are set; neither means a strobe-less no-op
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd) begin
            return OP_READ;
        end else if (wr) begin
            return OP_WRITE;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ram_responder.sv
// Asynchronous SRAM access sequencer: IDLE -> SETUP -> STROBE [-> STROBE2] -> DONE, four-phase handshake.
// Latency: request sampled at edge n gives ram_work_done from edge n+3 (n+4 with RAM_EXTRA_WAIT_EN).
// Backpressure: holds DONE (and write data) while ram_need_to_work stays high; returns to IDLE on its drop.
import ram_responder_pkg::*;

module ram_responder (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_need_to_work,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [`MemAddr]   addr,
    input  logic [`MemValue]  data,
    output logic              ram_work_done,
    output logic [`MemValue]  ram_feedback,
    output logic [`MemAddr]   ram_addr,
    inout  wire  [`MemValue]  ram_data,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_we
);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [`MemAddr]  addr_lat_q, addr_lat_d;
    logic [`MemValue] data_lat_q, data_lat_d;
    logic [`MemAddr]  ram_addr_q, ram_addr_d;
    logic [`MemValue] wdata_q, wdata_d;
    logic [`MemValue] feedback_q, feedback_d;
    logic             drv_q, drv_d;
    logic             en_q, en_d;
    logic             oe_q, oe_d;
    logic             we_q, we_d;
    logic             done_q, done_d;

    // Next state and next pin values; pins are registered from the current state, so
    // each phase's outputs appear one edge after the state is entered
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_lat_d = addr_lat_q;
        data_lat_d = data_lat_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        feedback_d = feedback_q;
        drv_d      = drv_q;
        en_d       = en_q;
        oe_d       = oe_q;
        we_d       = we_q;
        done_d     = done_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                en_d   = 1'b1;
                oe_d   = 1'b1;
                we_d   = 1'b1;
                drv_d  = 1'b0;
                if (ram_need_to_work) begin
                    op_d       = decode_op(mem_rd, mem_wr);
                    addr_lat_d = addr;
                    data_lat_d = data;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ram_addr_d = addr_lat_q;
                wdata_d    = data_lat_q;
                en_d       = (op_q == OP_NONE);
                oe_d       = (op_q != OP_READ);
                we_d       = 1'b1;
                drv_d      = (op_q == OP_WRITE);
                state_d    = ST_STROBE;
            end
            ST_STROBE: begin
                we_d = (op_q != OP_WRITE);
`ifdef RAM_EXTRA_WAIT_EN
                state_d = ST_STROBE2;
`else
                state_d = ST_DONE;
                if (op_q == OP_READ) begin
                    feedback_d = ram_data;
                end
`endif
            end
`ifdef RAM_EXTRA_WAIT_EN
            ST_STROBE2: begin
                we_d    = (op_q != OP_WRITE);
                state_d = ST_DONE;
                if (op_q == OP_READ) begin
                    feedback_d = ram_data;
                end
            end
`endif
            ST_DONE: begin
                en_d = 1'b1;
                oe_d = 1'b1;
                we_d = 1'b1;
                if (ram_need_to_work) begin
                    done_d = 1'b1;
                    drv_d  = (op_q == OP_WRITE);
                end else begin
                    done_d  = 1'b0;
                    drv_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latches and registered SRAM pins; reset releases every strobe on the reset edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            addr_lat_q <= '0;
            data_lat_q <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            feedback_q <= '0;
            drv_q      <= 1'b0;
            en_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_lat_q <= addr_lat_d;
            data_lat_q <= data_lat_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            feedback_q <= feedback_d;
            drv_q      <= drv_d;
            en_q       <= en_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            done_q     <= done_d;
        end
    end

    assign ram_data      = drv_q ? wdata_q : 'z;
    assign ram_addr      = ram_addr_q;
    assign ram_en        = en_q;
    assign ram_oe        = oe_q;
    assign ram_we        = we_q;
    assign ram_work_done = done_q;
    assign ram_feedback  = feedback_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized scoreboard bench for ram_responder against an asynchronous SRAM model.
// Latency: expects done at request edge + 3 (+4 when RAM_EXTRA_WAIT_EN is defined).
// Backpressure: stimulus holds the request for a random number of cycles after done.
module tb_ram_responder;

`ifdef RAM_EXTRA_WAIT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        need;
    logic        mem_rd;
    logic        mem_wr;
    logic [17:0] addr;
    logic [15:0] data;
    logic        done;
    logic [15:0] fb;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_en;
    logic        ram_oe;
    logic        ram_we;

    ram_responder dut (
        .clk              (clk),
        .rst              (rst),
        .ram_need_to_work (need),
        .mem_rd           (mem_rd),
        .mem_wr           (mem_wr),
        .addr             (addr),
        .data             (data),
        .ram_work_done    (done),
        .ram_feedback     (fb),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_en           (ram_en),
        .ram_oe           (ram_oe),
        .ram_we           (ram_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- asynchronous SRAM model ----------------
    bit   [15:0] sram [bit [17:0]];
    logic [15:0] sram_out = 16'h0;

    always @(negedge clk) begin
        if (!ram_en && !ram_we) sram[ram_addr] = ram_data;
        sram_out = sram.exists(ram_addr) ? sram[ram_addr] : 16'h0;
    end

    assign ram_data = (!ram_en && !ram_oe && ram_we) ? sram_out : 16'hzzzz;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          req_cyc;
        logic [15:0] fb;
        int          n_en;
        int          n_oe;
        int          n_we;
        int          n_drv;
        logic [17:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        sbq[$];
    bit   [15:0] ref_mem [bit [17:0]];
    logic [15:0] ref_fb = 16'h0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int   en_c, oe_c, we_c, drv_c, bad_c;
    logic done_p = 1'b0;
    logic need_p = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            en_c = 0; oe_c = 0; we_c = 0; drv_c = 0; bad_c = 0;
            done_p = 1'b0;
            need_p = 1'b0;
        end else begin
            if (done_p) begin
                if (need_p) chk("done_hold", {31'b0, done}, 32'd1);
                else        chk("done_drop", {31'b0, done}, 32'd0);
            end
            if (!done) begin
                if (!ram_en) begin
                    en_c++;
                    if (sbq.size() == 0 || ram_addr !== sbq[0].a) bad_c++;
                end
                if (!ram_oe) oe_c++;
                if (!ram_we) we_c++;
                if (ram_oe && ram_data !== 16'hzzzz) begin
                    drv_c++;
                    if (sbq.size() == 0 || ram_data !== sbq[0].d) bad_c++;
                end
                if (!ram_oe && $isunknown(ram_data)) bad_c++;
            end else if (!done_p) begin
                if (ram_data !== 16'hzzzz) begin
                    drv_c++;
                    if (sbq.size() == 0 || ram_data !== sbq[0].d) bad_c++;
                end
                if (!ram_en || !ram_oe || !ram_we) bad_c++;
                chk("sb_nonempty", {31'b0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("latency",   cyc - e.req_cyc, 3 + EXTRA);
                    chk("feedback",  {16'b0, fb}, {16'b0, e.fb});
                    chk("en_cycles", en_c, e.n_en);
                    chk("oe_cycles", oe_c, e.n_oe);
                    chk("we_cycles", we_c, e.n_we);
                    chk("drv_cycles", drv_c, e.n_drv);
                    chk("pin_errors", bad_c, 0);
                end
                en_c = 0; oe_c = 0; we_c = 0; drv_c = 0; bad_c = 0;
            end else begin
                if (!ram_en || !ram_oe || !ram_we) bad_c++;
            end
            done_p = done;
            need_p = need;
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input bit rd, input bit wr, input logic [17:0] a,
                          input logic [15:0] d, input int hold);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; addr = a; data = d; need = 1'b1;
        e.req_cyc = cyc + 1;
        e.a = a;
        e.d = d;
        if (rd) begin
            ref_fb = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
            e.n_en = 2 + EXTRA; e.n_oe = 2 + EXTRA; e.n_we = 0; e.n_drv = 0;
        end else if (wr) begin
            ref_mem[a] = d;
            e.n_en = 2 + EXTRA; e.n_oe = 0; e.n_we = 1 + EXTRA; e.n_drv = 3 + EXTRA;
        end else begin
            e.n_en = 0; e.n_oe = 0; e.n_we = 0; e.n_drv = 0;
        end
        e.fb = ref_fb;
        sbq.push_back(e);
        // Inputs move after the latch edge; the access must ignore them
        @(posedge clk); #1;
        mem_rd = 1'($urandom); mem_wr = 1'($urandom);
        addr = 18'($urandom); data = 16'($urandom);
        waited = 0;
        while (done !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("done_timeout", {31'b0, done}, 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        need = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int wt;
        logic [17:0] ra;
        logic [15:0] rd_;
        rst = 1'b1; need = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_fb",   {16'b0, fb}, 32'd0);
        chk("rst_addr", {14'b0, ram_addr}, 32'd0);
        chk("rst_strobes", {29'b0, ram_en, ram_oe, ram_we}, 32'd7);
        chk("rst_data_z", {31'b0, ram_data === 16'hzzzz}, 32'd1);
        rst = 1'b0;

        access(1'b0, 1'b1, 18'h00012, 16'hBEEF, 0);
        access(1'b1, 1'b0, 18'h00012, 16'h0000, 5);
        access(1'b1, 1'b1, 18'h00012, 16'h1234, 1);
        access(1'b0, 1'b0, 18'h00012, 16'h5555, 0);
        access(1'b0, 1'b1, 18'h3FFFF, 16'hA5A5, 2);
        access(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 0);

        // Reset in the middle of a write strobe
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b1; addr = 18'h00345; data = 16'hC0DE; need = 1'b1;
        wt = 0;
        while (ram_we !== 1'b0 && wt < 10) begin
            @(posedge clk); #1;
            wt++;
        end
        chk("abort_we_seen", {31'b0, ram_we}, 32'd0);
        rst = 1'b1;
        ref_mem[18'h00345] = 16'hC0DE;
        ref_fb = 16'h0;
        @(posedge clk); #1;
        chk("abort_we",   {31'b0, ram_we}, 32'd1);
        chk("abort_en",   {31'b0, ram_en}, 32'd1);
        chk("abort_data_z", {31'b0, ram_data === 16'hzzzz}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_fb",   {16'b0, fb}, 32'd0);
        rst = 1'b0; need = 1'b0;

        access(1'b0, 1'b0, 18'h00001, 16'h0001, 0);
        access(1'b1, 1'b0, 18'h00345, 16'h0000, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 18'h00012;
                1:       ra = 18'h3FFFF;
                2:       ra = 18'h00345;
                default: ra = 18'($urandom_range(0, 7));
            endcase
            rd_ = 16'($urandom);
            access(1'($urandom), 1'($urandom), ra, rd_, $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: synchronous active-high reset.
REQ-004 Port ram_need_to_work, input, 1: access request level from the RAM controller.
REQ-005 Port mem_rd, input, 1: read request qualifier.
REQ-006 Port mem_wr, input, 1: write request qualifier.
REQ-007 Port addr, input, `MemAddr (18 bits): access address.
REQ-008 Port data, input, `MemValue (16 bits): write data.
REQ-009 Port ram_work_done, output, 1: access complete.
REQ-010 Port ram_feedback, output, `MemValue: read result.
REQ-011 Port ram_addr, output, `MemAddr: SRAM address pins.
REQ-012 Port ram_data, inout, `MemValue: SRAM data pins, tri-stated when not driven.
REQ-013 Ports ram_en, ram_oe, ram_we, output, 1 each: SRAM chip-enable, output-enable and write-enable, all active-low.

Function
REQ-014 The state machine SHALL have states IDLE, SETUP, STROBE, (STROBE2 only when the configuration macro is defined) and DONE.
REQ-015 In IDLE with ram_need_to_work=1 at an edge, the block SHALL latch mem_rd, mem_wr, addr and data, and move to SETUP.
REQ-016 Operation select: mem_rd=1 SHALL give a read, even if mem_wr=1 (read priority); mem_wr=1 alone SHALL give a write; neither SHALL give a no-op with no strobes.
REQ-017 SETUP SHALL drive ram_addr from the latch and assert ram_en=0; a read SHALL assert ram_oe=0; a write SHALL drive ram_data.
REQ-018 STROBE SHALL hold SETUP outputs, and a write SHALL additionally assert ram_we=0 for exactly that state.
REQ-019 A read SHALL register ram_data into ram_feedback on the edge leaving the last strobe state.
REQ-020 DONE SHALL assert ram_work_done=1, set ram_en, ram_oe and ram_we to 1, and keep ram_data driven for a write (hold cycle).
REQ-021 The block SHALL stay in DONE while ram_need_to_work=1, and go to IDLE on the first edge with ram_need_to_work=0 (four-phase handshake).
REQ-022 Latency: request sampled at edge n gives ram_work_done=1 from edge n+3 (n+4 with the macro).
REQ-023 ram_feedback SHALL hold its last value until the next read completes; writes and no-ops SHALL leave it unchanged.
REQ-024 Input changes after the latch edge SHALL NOT affect an access in progress.
REQ-025 ram_data SHALL be high-impedance in IDLE, for all reads, and for no-ops.

Reset
REQ-026 With rst=1 at an edge:
  - state SHALL become IDLE;
  - ram_work_done=0 and ram_feedback=0;
  - ram_addr=0;
  - ram_en, ram_oe, ram_we=1;
  - ram_data SHALL be tri-stated.
REQ-027 A reset mid-access SHALL abort the access with no strobe glitch; the write strobe SHALL deassert on the reset edge.

Configuration
REQ-028 Macro RAM_EXTRA_WAIT_EN defined: STROBE2 SHALL follow STROBE, with identical outputs, adding one cycle of latency. Undefined: STROBE SHALL go directly to DONE.

Structure
REQ-029 `MemAddr, `MemValue and the state encodings SHALL live in the shared defines header.
REQ-030 The design SHALL be a single module; no sub-module.

Verification
REQ-031 Write: addr=0x00012, data=0xBEEF, mem_wr=1, need=1.
  - ram_we=0 in exactly one cycle;
  - ram_data=0xBEEF through SETUP, STROBE and DONE;
  - ram_work_done=1 at n+3.
REQ-032 Read back from the SRAM model at addr 0x00012: ram_oe=0 for 2 cycles; ram_feedback=0xBEEF with ram_work_done=1 at n+3.
REQ-033 Hold ram_need_to_work=1 for 5 cycles after done: ram_work_done stays 1; drop it, and IDLE plus ram_work_done=0 follow one edge later.
REQ-034 mem_rd=mem_wr=1: read performed and ram_we stays 1; mem_rd=mem_wr=0: done at n+3, no strobes, ram_feedback unchanged.
REQ-035 Assert rst during the write STROBE: next edge gives ram_we=1, ram_data Z, ram_work_done=0, ram_feedback=0, state IDLE.
REQ-036 With RAM_EXTRA_WAIT_EN defined: write ram_we=0 for 2 cycles; done at n+4.
